// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache requesters, with registered grants.
// Optional bounded bursting per grant is compiled in with `define ARB_BURST_EN.
module ram_arbiter #(
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NREQ-1:0]        req_ren,
    input  logic [NREQ-1:0]        req_wen,
    input  logic [NREQ*32-1:0]     req_addr,
    input  logic [NREQ*32-1:0]     req_store,
    output logic [NREQ-1:0]        req_wait,
    output logic [31:0]            req_load,
    input  logic [1:0]             ramstate,
    input  logic [31:0]            ramload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    output logic                   gnt_valid,
    output logic [$clog2(NREQ)-1:0] gnt_id
);

    localparam int IDW = $clog2(NREQ);

    // ramstate encoding shared with the RAM model
    localparam logic [1:0] RAM_FREE   = 2'd0;
    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDW-1:0]   gnt_id_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic [IDW-1:0]   pick_s;
    logic [IDW-1:0]   nxt_ptr_s;
    logic [NREQ-1:0]  req_s;
    logic             g_req_s;
    logic             load_gnt_s;
    logic             rotate_s;
    logic             last_beat_s;
    logic             burst_inc_s;

`ifdef ARB_BURST_EN
    localparam int BCW = $clog2(BURST) + 1;
    logic [BCW-1:0]   burst_cnt_r;

    assign last_beat_s = (burst_cnt_r >= BCW'(BURST - 1));
`else
    assign last_beat_s = 1'b1;
`endif

    assign req_s     = req_ren | req_wen;
    assign g_req_s   = req_s[gnt_id_r];
    assign nxt_ptr_s = (gnt_id_r == IDW'(NREQ - 1)) ? '0 : gnt_id_r + 1'b1;
    assign req_load  = ramload;
    assign gnt_valid = (state_r == GRANT);
    assign gnt_id    = gnt_id_r;

    // Round-robin pick: scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx    = 0;
        pick_s = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_r) + k) % NREQ;
            if (req_s[idx]) begin
                pick_s = IDW'(idx);
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // Next-state logic and RAM-side/requester-side outputs.
    always_comb begin
        state_nxt_s = state_r;
        load_gnt_s  = 1'b0;
        rotate_s    = 1'b0;
        burst_inc_s = 1'b0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = 32'h0000_0000;
        ramstore    = 32'h0000_0000;
        req_wait    = '1;
        case (state_r)
            IDLE: begin
                if (|req_s) begin
                    state_nxt_s = GRANT;
                    load_gnt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                ramaddr  = req_addr[32*int'(gnt_id_r) +: 32];
                ramstore = req_store[32*int'(gnt_id_r) +: 32];
                if (g_req_s) begin
                    ramWEN = req_wen[gnt_id_r];
                    ramREN = req_ren[gnt_id_r] & ~req_wen[gnt_id_r];
                    // ERROR is deliberately treated like BUSY: the grant is held.
                    if (ramstate == RAM_ACCESS) begin
                        req_wait[gnt_id_r] = 1'b0;
                        if (last_beat_s) begin
                            state_nxt_s = IDLE;
                            rotate_s    = 1'b1;
                        end else begin
                            state_nxt_s = GRANT;
                            burst_inc_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = GRANT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                    rotate_s    = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r  <= IDLE;
            gnt_id_r <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (load_gnt_s) begin
                gnt_id_r <= pick_s;
            end
            if (rotate_s) begin
                rr_ptr_r <= nxt_ptr_s;
            end
        end
    end

`ifdef ARB_BURST_EN
    // Beats completed within the current grant.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            burst_cnt_r <= '0;
        end else if (load_gnt_s) begin
            burst_cnt_r <= '0;
        end else if (burst_inc_s) begin
            burst_cnt_r <= burst_cnt_r + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (default build, no bursting).
module tb_ram_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic         CLK = 1'b0;
    logic         nRST;
    logic [3:0]   ren, wen, req_wait;
    logic [127:0] addr, store;
    logic [31:0]  req_load, ramload, ramaddr, ramstore;
    logic [1:0]   ramstate;
    logic         ramREN, ramWEN, gnt_valid;
    logic [1:0]   gnt_id;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.NREQ(4), .BURST(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_ren(ren), .req_wen(wen), .req_addr(addr), .req_store(store),
        .req_wait(req_wait), .req_load(req_load),
        .ramstate(ramstate), .ramload(ramload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .gnt_valid(gnt_valid), .gnt_id(gnt_id)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        nRST     = 1'b0;
        ren      = 4'hF;
        wen      = 4'h0;
        ramstate = FREE;
        ramload  = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            addr[i*32 +: 32]  = 32'h100 + 32'(i);
            store[i*32 +: 32] = 32'hA000 + 32'(i);
        end

        // Reset held two cycles with every requester active
        step();
        step();
        #1;
        chk("rst_ren", {31'd0, ramREN}, 32'd0);
        chk("rst_wen", {31'd0, ramWEN}, 32'd0);
        chk("rst_wait", {28'd0, req_wait}, 32'hF);
        chk("rst_gv", {31'd0, gnt_valid}, 32'd0);
        chk("rst_gid", {30'd0, gnt_id}, 32'd0);
        chk("rst_addr", ramaddr, 32'd0);
        chk("rst_store", ramstore, 32'd0);
        nRST = 1'b1;
        step();

        // Fairness: all read, 1 BUSY cycle then ACCESS, 3 cycles per transaction
        for (int t = 0; t < 8; t++) begin
            ramstate = BUSY;
            #1;
            chk("rr_gv", {31'd0, gnt_valid}, 32'd1);
            chk("rr_gid", {30'd0, gnt_id}, 32'(t % 4));
            chk("rr_ren", {31'd0, ramREN}, 32'd1);
            chk("rr_addr", ramaddr, 32'h100 + 32'(t % 4));
            chk("rr_wait_busy", {28'd0, req_wait}, 32'hF);
            step();
            ramstate = ACCESS;
            #1;
            chk("rr_wait_acc", {28'd0, req_wait}, 32'hF & ~(32'd1 << (t % 4)));
            step();
            ramstate = FREE;
            #1;
            chk("rr_idle_gv", {31'd0, gnt_valid}, 32'd0);
            chk("rr_idle_ren", {31'd0, ramREN}, 32'd0);
            chk("rr_idle_wait", {28'd0, req_wait}, 32'hF);
            step();
        end

        // ERROR behaves as BUSY: grant held, no completion
        ramstate = ERROR;
        #1;
        chk("err_wait", {28'd0, req_wait}, 32'hF);
        chk("load_bcast", req_load, 32'h1234_5678);
        step();
        #1;
        chk("err_gv", {31'd0, gnt_valid}, 32'd1);
        chk("err_gid", {30'd0, gnt_id}, 32'd0);

        // Drop id 0 mid-grant: strobes low at once, IDLE next, rr_ptr -> 1
        ren      = 4'h0;
        ramstate = BUSY;
        #1;
        chk("drop0_ren", {31'd0, ramREN}, 32'd0);
        step();
        #1;
        chk("drop0_gv", {31'd0, gnt_valid}, 32'd0);

        // Write precedence for id 2
        ren = 4'b0100;
        wen = 4'b0100;
        addr[64 +: 32]  = 32'h40;
        store[64 +: 32] = 32'hDEAD_BEEF;
        step();
        ramstate = BUSY;
        #1;
        chk("wr_gid", {30'd0, gnt_id}, 32'd2);
        chk("wr_wen", {31'd0, ramWEN}, 32'd1);
        chk("wr_ren", {31'd0, ramREN}, 32'd0);
        chk("wr_addr", ramaddr, 32'h40);
        chk("wr_store", ramstore, 32'hDEAD_BEEF);
        step();
        ramstate = ACCESS;
        #1;
        chk("wr_wait", {28'd0, req_wait}, 32'b1011);
        step();
        ren      = 4'h0;
        wen      = 4'h0;
        ramstate = FREE;
        #1;
        chk("wr_idle_gv", {31'd0, gnt_valid}, 32'd0);

        // Abort: id 1 granted (rr_ptr 3 wraps), drops before ACCESS; id 2 pending
        ren = 4'b0010;
        step();
        ren      = 4'b0110;
        ramstate = BUSY;
        #1;
        chk("ab_gid", {30'd0, gnt_id}, 32'd1);
        chk("ab_addr", ramaddr, 32'h101);
        chk("ab_ren", {31'd0, ramREN}, 32'd1);
        step();
        ren      = 4'b0100;
        ramstate = ACCESS;
        #1;
        chk("ab_drop_ren", {31'd0, ramREN}, 32'd0);
        chk("ab_no_cmpl", {28'd0, req_wait}, 32'hF);
        step();
        ramstate = FREE;
        #1;
        chk("ab_idle_gv", {31'd0, gnt_valid}, 32'd0);
        step();
        #1;
        chk("ab_next_gid", {30'd0, gnt_id}, 32'd2);
        chk("ab_next_ren", {31'd0, ramREN}, 32'd1);
        chk("ab_next_addr", ramaddr, 32'h40);
        ramstate = ACCESS;
        #1;
        chk("ab_next_wait", {28'd0, req_wait}, 32'b1011);
        step();

        // Reset during BUSY for id 3
        ren      = 4'b1000;
        ramstate = FREE;
        step();
        #1;
        chk("mr_gid3", {30'd0, gnt_id}, 32'd3);
        ramstate = BUSY;
        nRST     = 1'b0;
        step();
        #1;
        chk("mr_gv", {31'd0, gnt_valid}, 32'd0);
        chk("mr_gid", {30'd0, gnt_id}, 32'd0);
        chk("mr_wait", {28'd0, req_wait}, 32'hF);
        chk("mr_ren", {31'd0, ramREN}, 32'd0);
        nRST     = 1'b1;
        ren      = 4'hF;
        ramstate = FREE;
        step();
        #1;
        chk("mr_ptr0", {30'd0, gnt_id}, 32'd0);

        // Single requester: one IDLE cycle, then re-grant to itself via wrap
        ren      = 4'b0001;
        ramstate = ACCESS;
        #1;
        chk("rg_wait", {28'd0, req_wait}, 32'b1110);
        step();
        ramstate = FREE;
        #1;
        chk("rg_idle_gv", {31'd0, gnt_valid}, 32'd0);
        step();
        #1;
        chk("rg_gv", {31'd0, gnt_valid}, 32'd1);
        chk("rg_gid", {30'd0, gnt_id}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares the single RAM port between NREQ cache requesters (ordering: cpu0 dcache, cpu0 icache, cpu1 dcache, cpu1 icache) for the dual-core build. It sits between the caches' request ports and the RAM, upstream of the coherence logic's memory path. It replaces fixed data-over-instruction priority with fair, registered grants. A grant is held for a full RAM transaction, or for a bounded burst when bursting is compiled in.

## Interface
- NREQ, 4, number of requesters; requester index = position in the packed vectors
- BURST, 4, maximum consecutive transactions per grant (used only with ARB_BURST_EN)
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- req_ren  in  NREQ  read request per requester
- req_wen  in  NREQ  write request per requester (ren and wen both high: write)
- req_addr  in  NREQ x 32  word address per requester
- req_store  in  NREQ x 32  write data per requester
- req_wait  out  NREQ  per-requester wait; low for exactly one cycle marks completion
- req_load  out  32  broadcast read data (= ramload)
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR from RAM
- ramload  in  32  RAM read data
- ramREN, ramWEN  out  1 each  RAM strobes
- ramaddr, ramstore  out  32 each  RAM address/data
- gnt_valid  out  1  a grant is held
- gnt_id  out  clog2(NREQ)  granted requester index

## Operation
- req[i] = req_ren[i] | req_wen[i].
- States: IDLE, GRANT.
- IDLE: ram strobes low; all req_wait high.
  - If any req, choose the first requesting index at or after rr_ptr (wrapping modulo NREQ).
  - Register gnt_id; go to GRANT; clear burst count.
- GRANT: ramaddr/ramstore = granted requester's addr/store; ramWEN = req_wen[g]; ramREN = req_ren[g] & ~req_wen[g].
- ramstate==ACCESS in GRANT: req_wait[g]=0 that cycle (combinational); all other waits stay high.
  - Set rr_ptr <= (g+1) mod NREQ.
  - Return to IDLE, except under the burst rule.
- Requester drops req while in GRANT without ACCESS: strobes go low that cycle (combinational from req); next state IDLE; no completion; rr_ptr <= (g+1) mod NREQ.
- ramstate==ERROR: treated as BUSY; grant held.
- Non-granted requesters are never driven onto the RAM port.
- Starvation bound: with all requesters active, a request waits at most NREQ-1 transactions (x BURST with ARB_BURST_EN).

## Timing
- Reset (nRST low at edge): state IDLE, rr_ptr 0, gnt_valid 0, gnt_id 0, burst count 0. Combinational outputs then read ramREN 0, ramWEN 0, ramaddr 0, ramstore 0, req_wait all 1.
- Reset asserted mid-GRANT: grant dropped at that edge; no completion issued.
- Arbitration latency: request high in cycle N (IDLE) -> RAM strobes driven in cycle N+1.
- Completion: req_wait low in the same cycle ramstate==ACCESS.
- Minimum turnaround is 1 IDLE cycle between grants, including a re-grant to the same requester.
- Single requester, RAM latency L cycles to ACCESS: L+1 cycles per transaction.
- rr_ptr wraps NREQ-1 -> 0.
- gnt_valid and gnt_id are registered and change only on edges.

## Configuration
- ARB_BURST_EN defined:
  - On ACCESS in GRANT, if burst count < BURST-1: stay in GRANT and increment the count; rr_ptr is not updated.
  - The next cycle drives the requester's new addr/store if it still requests; a dropped request releases as above.
  - At burst count BURST-1, release normally with rr_ptr <= g+1.
  - Back-to-back transactions then have no IDLE gap.
- ARB_BURST_EN undefined: burst count logic absent; every ACCESS returns to IDLE and rotates rr_ptr.

## Test plan
- Reset: hold nRST low 2 cycles with all req high -> ramREN=ramWEN=0, req_wait=4'b1111, gnt_valid=0; first grant after release goes to id 0.
- Fairness: all four read continuously, RAM latency 2 -> grants 0,1,2,3,0,... with each req_wait low once per 4 transactions; no ARB_BURST_EN.
- Write precedence: id 2 asserts ren and wen, addr 0x40, store 0xDEADBEEF -> ramWEN=1, ramREN=0, ramaddr=0x40, ramstore=0xDEADBEEF; req_wait[2] low on ACCESS.
- Abort: id 1 granted, drops req_ren before ACCESS -> strobes low same cycle, IDLE next, no req_wait[1] pulse; id 2 (pending) granted next.
- Reset mid-GRANT: nRST low during BUSY for id 3 -> gnt_valid 0 next edge, rr_ptr 0, no completion.
- Burst (ARB_BURST_EN, BURST=4): ids 0 and 1 both requesting continuously -> id 0 gets 4 completions with no IDLE gap, then id 1 granted after one IDLE cycle.
